// File: rtl/if_stage.sv
// Instruction fetch: owns the PC and runs a Wishbone-classic read master, presenting one slot.
// Latency: ack sampled at edge N -> valid_if after edge N; next request starts after the consume edge.
// Backpressure: stall_i=1 freezes a full slot and keeps the bus idle; redirect_i overrides stall_i.
module if_stage #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic [31:0] iwbm_addr_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i,
  output logic [31:0] instr_if,
  output logic [31:0] PC_if,
  output logic [31:0] PC4_if,
  output logic [3:0]  trap_code_if,
  output logic        is_trap_if,
  output logic        valid_if
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [3:0] TRAP_MISALIGNED = 4'd0;
  localparam logic [3:0] TRAP_ACCESS     = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_STOP,
    S_DRAIN
  } state_e;

  // One output slot as seen by the IF/ID register.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [3:0]  code;
    logic        trap;
  } slot_t;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cyc_q, cyc_d;
  logic [31:0]      addr_q, addr_d;
  slot_t            slot_q, slot_d;
  logic             valid_q, valid_d;

  logic             timeout;
  logic             bus_done;
  logic             go;
  logic [31:0]      go_pc;

  // A cycle that has been open for TIMEOUT_CYCLES edges without a response is treated as an error.
  assign timeout  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_done = iwbm_ack_i | iwbm_err_i | timeout;

  // Next-state logic; every path that launches a fetch funnels through 'go' so the
  // misaligned-target check and counter clear live in exactly one place.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q + CNT_W'(1);
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    go      = 1'b0;
    go_pc   = pc_q;

    case (state_q)
      S_IDLE: begin
        go    = 1'b1;
        go_pc = redirect_i ? target_i : pc_q;
      end

      S_REQ: begin
        if (redirect_i) begin
          if (bus_done) begin
            // Response of the squashed fetch is dropped; new fetch starts right away.
            go    = 1'b1;
            go_pc = target_i;
          end else begin
            // Cycle must run to completion before the bus may be released.
            state_d = S_DRAIN;
            pc_d    = target_i;
            cnt_d   = '0;
          end
        end else if (iwbm_ack_i) begin
          slot_d.instr = iwbm_dat_i;
          slot_d.pc    = pc_q;
          slot_d.pc4   = pc_q + 32'd4;
          slot_d.code  = 4'd0;
          slot_d.trap  = 1'b0;
          valid_d      = 1'b1;
          pc_d         = pc_q + 32'd4;
          cyc_d        = 1'b0;
          state_d      = S_HOLD;
        end else if (iwbm_err_i || timeout) begin
          slot_d.instr = 32'd0;
          slot_d.pc    = pc_q;
          slot_d.pc4   = pc_q + 32'd4;
          slot_d.code  = TRAP_ACCESS;
          slot_d.trap  = 1'b1;
          valid_d      = 1'b1;
          cyc_d        = 1'b0;
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          go    = 1'b1;
          go_pc = target_i;
        end else if (!stall_i) begin
          if (slot_q.trap) begin
            // Trap handed downstream: stay quiet until the core redirects.
            slot_d  = '0;
            valid_d = 1'b0;
            state_d = S_STOP;
          end else begin
            go    = 1'b1;
            go_pc = pc_q;
          end
        end
      end

      S_STOP: begin
        if (redirect_i) begin
          go    = 1'b1;
          go_pc = target_i;
        end
      end

      S_DRAIN: begin
        if (redirect_i) begin
          pc_d = target_i;
        end
        if (bus_done) begin
          go    = 1'b1;
          go_pc = redirect_i ? target_i : pc_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    if (go) begin
      pc_d    = go_pc;
      slot_d  = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      if (go_pc[1:0] != 2'b00) begin
        // Misaligned target never reaches the bus; it becomes a trap slot.
        slot_d.pc   = go_pc;
        slot_d.pc4  = go_pc + 32'd4;
        slot_d.code = TRAP_MISALIGNED;
        slot_d.trap = 1'b1;
        valid_d     = 1'b1;
        cyc_d       = 1'b0;
        state_d     = S_HOLD;
      end else begin
        cyc_d   = 1'b1;
        addr_d  = go_pc;
        state_d = S_REQ;
      end
    end
  end

  // State and output registers; reset aborts any open bus cycle immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      addr_q  <= 32'd0;
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign iwbm_addr_o  = addr_q;
  assign iwbm_cyc_o   = cyc_q;
  assign iwbm_stb_o   = cyc_q;
  assign instr_if     = slot_q.instr;
  assign PC_if        = slot_q.pc;
  assign PC4_if       = slot_q.pc4;
  assign trap_code_if = slot_q.code;
  assign is_trap_if   = slot_q.trap;
  assign valid_if     = valid_q;

endmodule
